// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the uart_tx byte port.
// The slave modport is the arbiter's view; master is the requester/uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              grant;
    logic                            uart_tx_en;
    logic [PAYLOAD_BITS-1:0]         uart_tx_data;
    logic                            uart_tx_busy;
    logic                            arb_busy;

    modport slave (
        input  req_valid, req_last, req_data, uart_tx_busy,
        output req_ready, grant, uart_tx_en, uart_tx_data, arb_busy
    );

    modport master (
        output req_valid, req_last, req_data, uart_tx_busy,
        input  req_ready, grant, uart_tx_en, uart_tx_data, arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one uart_tx byte port; a grant is held for a whole packet.
// Define UART_ARB_TAG_EN to prefix each packet with a {4'hA, source} header byte.
//
// state  | meaning
// IDLE   | no owner, waiting for any req_valid
// ARB    | pick first valid requester from rr_q upward, register grant
// HDR    | send source tag byte (UART_ARB_TAG_EN builds only)
// SEND   | wait for owner byte and idle uart_tx, then strobe once
// LAUNCH | wait for uart_tx to report busy
// DRAIN  | wait for uart_tx to finish; next byte or release the packet
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input logic              clk,
    input logic              resetn,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
`ifdef UART_ARB_TAG_EN
        S_HDR    = 3'd2,
`endif
        S_SEND   = 3'd3,
        S_LAUNCH = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PW-1:0]           gidx_q, gidx_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic                    last_q, last_d;

    logic                    found;
    logic [PW-1:0]           pick;
    logic                    cur_valid;
    logic                    cur_last;
    logic [PAYLOAD_BITS-1:0] cur_data;
    logic [NUM_REQ-1:0]      ready;
    logic                    tx_en;
    logic [PAYLOAD_BITS-1:0] tx_data;
`ifdef UART_ARB_TAG_EN
    logic [PAYLOAD_BITS-1:0] hdr_byte;

    assign hdr_byte = PAYLOAD_BITS'({4'hA, 4'(gidx_q)});
`endif

    // Rotating priority: offset 0 is rr_q, first valid hit wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && bus.req_valid[j] && ((int'(rr_q) + off) % NUM_REQ) == j) begin
                    found = 1'b1;
                    pick  = PW'(j);
                end
            end
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_data  = bus.req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        last_d  = last_q;
        ready   = '0;
        tx_en   = 1'b0;
        tx_data = '0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                // A requester may withdraw between IDLE and ARB; fall back quietly.
                if (found) begin
                    grant_d = NUM_REQ'(1) << pick;
                    gidx_d  = pick;
`ifdef UART_ARB_TAG_EN
                    state_d = S_HDR;
`else
                    state_d = S_SEND;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            S_HDR: begin
                if (!bus.uart_tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = hdr_byte;
                    last_d  = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
`endif
            S_SEND: begin
                if (cur_valid && !bus.uart_tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = cur_data;
                    ready   = grant_q;
                    last_d  = cur_last;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.uart_tx_busy) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.uart_tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        rr_d    = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.grant        = grant_q;
    assign bus.uart_tx_en   = tx_en;
    assign bus.uart_tx_data = tx_data;
    assign bus.arb_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester FIFOs and a uart_tx busy model drive the DUT,
// expected bytes go to a scoreboard queue and are compared on each uart_tx_en.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int PB = 8;
`ifdef UART_ARB_TAG_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] ready;
        logic [3:0] grant;
    } exp_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         busy_len;
        logic [3:0] exp_grant;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] rq_data [NR][32];
    logic       rq_last [NR][32];
    int         rq_head [NR];
    int         rq_tail [NR];
    int         pop_pending;
    bit         launch_pending;
    int         busy_cnt;
    int         busy_len;
    bit         force_busy;
    int         en_count;
    int         idle_obs;
    int         ready_count [NR];
    int         n_pass;
    int         n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic req_push(input int idx, input logic [7:0] d, input logic l);
        if (rq_head[idx] == rq_tail[idx]) begin
            rq_head[idx] = 0;
            rq_tail[idx] = 0;
        end
        rq_data[idx][rq_tail[idx]] = d;
        rq_last[idx][rq_tail[idx]] = l;
        rq_tail[idx]++;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic [3:0] rdy, input logic [3:0] gnt);
        exp_t e;
        e.data  = d;
        e.ready = rdy;
        e.grant = gnt;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt_start(input int idx, input logic [3:0] gnt);
`ifdef UART_ARB_TAG_EN
        exp_push({4'hA, 4'(idx)}, 4'b0000, gnt);
`endif
    endtask

    task automatic drive_reqs();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*PB-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq_head[i] < rq_tail[i]) begin
                v[i]         = 1'b1;
                l[i]         = rq_last[i][rq_head[i]];
                d[i*PB +: PB] = rq_data[i][rq_head[i]];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic observe();
        exp_t e;
        if (!bus.arb_busy) idle_obs++;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) ready_count[i]++;
        if (bus.uart_tx_en) begin
            en_count++;
            check("en_while_busy", 32'(bus.uart_tx_busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_en_data", 32'(bus.uart_tx_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(bus.uart_tx_data), 32'(e.data));
                check("req_ready", 32'(bus.req_ready), 32'(e.ready));
                check("grant", 32'(bus.grant), 32'(e.grant));
            end
            launch_pending = 1'b1;
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) pop_pending = i;
        end else if (|bus.req_ready) begin
            check("ready_without_en", 32'(bus.req_ready), 0);
        end
    endtask

    // All stimulus changes at the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk);
        if (pop_pending >= 0) begin
            rq_head[pop_pending]++;
            pop_pending = -1;
        end
        if (launch_pending) begin
            busy_cnt       = busy_len;
            launch_pending = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.uart_tx_busy = force_busy || (busy_cnt > 0);
        drive_reqs();
        #1;
        observe();
    endtask

    task automatic wait_done(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            tick();
            done = (exp_q.size() == 0) && !bus.arb_busy && !bus.uart_tx_busy;
        end
        if (!done) check("wait_done_timeout", {bus.arb_busy, bus.uart_tx_busy, 30'(exp_q.size())}, 0);
    endtask

    task automatic wait_en(input int target, input int max_cycles);
        for (int c = 0; c < max_cycles && en_count < target; c++) tick();
        check("wait_en_reached", 32'(en_count >= target), 1);
    endtask

    initial begin
        vec_t vecs[5];
        int   base;
        int   rbase;

        vecs[0] = '{0, 8'h55, 10, 4'b0001};
        vecs[1] = '{1, 8'hA5,  3, 4'b0010};
        vecs[2] = '{2, 8'h00,  1, 4'b0100};
        vecs[3] = '{3, 8'hFF,  5, 4'b1000};
        vecs[4] = '{2, 8'h3C,  2, 4'b0100};

        n_pass = 0; n_total = 0; en_count = 0; idle_obs = 0;
        pop_pending = -1; launch_pending = 1'b0; busy_cnt = 0; busy_len = 4; force_busy = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0; rq_tail[i] = 0; ready_count[i] = 0;
        end
        bus.uart_tx_busy = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        resetn = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_tx_en", 32'(bus.uart_tx_en), 0);
        check("rst_tx_data", 32'(bus.uart_tx_data), 0);
        check("rst_arb_busy", 32'(bus.arb_busy), 0);
        resetn = 1'b1;
        tick();

        // Lone single-byte packets from the table.
        for (int k = 0; k < 5; k++) begin
            busy_len = vecs[k].busy_len;
            base     = en_count;
            exp_pkt_start(vecs[k].idx, vecs[k].exp_grant);
            exp_push(vecs[k].data, vecs[k].exp_grant, vecs[k].exp_grant);
            req_push(vecs[k].idx, vecs[k].data, 1'b1);
            wait_done(200);
            check("vec_grant_idle", 32'(bus.grant), 0);
            check("vec_en_count", 32'(en_count - base), 32'(HDR_N + 1));
        end

        // Grant stays on requester 0 through DRAIN, then clears.
        busy_len = 10;
        base     = en_count;
        exp_pkt_start(0, 4'b0001);
        exp_push(8'h55, 4'b0001, 4'b0001);
        req_push(0, 8'h55, 1'b1);
        wait_en(base + HDR_N + 1, 50);
        tick();
        tick();
        check("drain_grant", 32'(bus.grant), 32'h1);
        check("drain_arb_busy", 32'(bus.arb_busy), 1);
        wait_done(200);
        check("post_drain_grant", 32'(bus.grant), 0);

        // Two-byte packets from 1 and 3 raised together: no interleave, 1 then 3.
        busy_len = 3;
        exp_pkt_start(1, 4'b0010);
        exp_push(8'h10, 4'b0010, 4'b0010);
        exp_push(8'h11, 4'b0010, 4'b0010);
        exp_pkt_start(3, 4'b1000);
        exp_push(8'h30, 4'b1000, 4'b1000);
        exp_push(8'h31, 4'b1000, 4'b1000);
        req_push(1, 8'h10, 1'b0);
        req_push(1, 8'h11, 1'b1);
        req_push(3, 8'h30, 1'b0);
        req_push(3, 8'h31, 1'b1);
        wait_done(300);
        // Pointer wrapped back to 0, so requester 0 now beats requester 3.
        exp_pkt_start(0, 4'b0001);
        exp_push(8'h01, 4'b0001, 4'b0001);
        exp_pkt_start(3, 4'b1000);
        exp_push(8'h03, 4'b1000, 4'b1000);
        req_push(3, 8'h03, 1'b1);
        req_push(0, 8'h01, 1'b1);
        wait_done(300);

        // uart_tx busy at accept time: strobe held off, then exactly one per byte.
        force_busy = 1'b1;
        base       = en_count;
        exp_pkt_start(2, 4'b0100);
        exp_push(8'h77, 4'b0100, 4'b0100);
        req_push(2, 8'h77, 1'b1);
        for (int c = 0; c < 8; c++) tick();
        check("busy_hold_no_en", 32'(en_count - base), 0);
        check("busy_hold_grant", 32'(bus.grant), 32'h4);
        force_busy = 1'b0;
        wait_done(100);
        check("busy_release_en_count", 32'(en_count - base), 32'(HDR_N + 1));

        // Lone requester back-to-back: exactly one IDLE cycle between packets.
        busy_len = 2;
        base     = en_count;
        exp_pkt_start(1, 4'b0010);
        exp_push(8'h21, 4'b0010, 4'b0010);
        exp_pkt_start(1, 4'b0010);
        exp_push(8'h22, 4'b0010, 4'b0010);
        req_push(1, 8'h21, 1'b1);
        req_push(1, 8'h22, 1'b1);
        wait_en(base + HDR_N + 1, 50);
        idle_obs = 0;
        wait_en(base + HDR_N + 2, 50);
        check("b2b_idle_cycles", 32'(idle_obs), 1);
        wait_done(100);

        // Requester withdraws mid-packet: SEND stalls with grant held.
        base = en_count;
        exp_pkt_start(1, 4'b0010);
        exp_push(8'h61, 4'b0010, 4'b0010);
        req_push(1, 8'h61, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        check("stall_grant", 32'(bus.grant), 32'h2);
        check("stall_arb_busy", 32'(bus.arb_busy), 1);
        check("stall_en_count", 32'(en_count - base), 32'(HDR_N + 1));
        exp_push(8'h62, 4'b0010, 4'b0010);
        req_push(1, 8'h62, 1'b1);
        wait_done(100);

        // Reset during DRAIN of byte 2 of 3 aborts the packet for good.
        busy_len = 6;
        base     = en_count;
        exp_pkt_start(2, 4'b0100);
        exp_push(8'hB0, 4'b0100, 4'b0100);
        exp_push(8'hB1, 4'b0100, 4'b0100);
        exp_push(8'hB2, 4'b0100, 4'b0100);
        req_push(2, 8'hB0, 1'b0);
        req_push(2, 8'hB1, 1'b0);
        req_push(2, 8'hB2, 1'b1);
        wait_en(base + HDR_N + 2, 100);
        tick();
        tick();
        check("pre_reset_grant", 32'(bus.grant), 32'h4);
        resetn = 1'b0;
        #1;
        check("mid_rst_grant", 32'(bus.grant), 0);
        check("mid_rst_arb_busy", 32'(bus.arb_busy), 0);
        check("mid_rst_tx_en", 32'(bus.uart_tx_en), 0);
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_tx_data", 32'(bus.uart_tx_data), 0);
        rq_head[2] = rq_tail[2];
        exp_q.delete();
        pop_pending = -1;
        tick();
        tick();
        resetn = 1'b1;
        base   = en_count;
        for (int c = 0; c < 20; c++) tick();
        check("post_rst_no_en", 32'(en_count - base), 0);
        check("post_rst_idle", 32'(bus.arb_busy), 0);

`ifdef UART_ARB_TAG_EN
        // Tagged packet from requester 2: header then payload, one ready pulse.
        busy_len = 3;
        rbase    = ready_count[2];
        exp_push(8'hA2, 4'b0000, 4'b0100);
        exp_push(8'h41, 4'b0100, 4'b0100);
        req_push(2, 8'h41, 1'b1);
        wait_done(100);
        check("tag_ready_pulses", 32'(ready_count[2] - rbase), 1);
`else
        // Untagged: the first requester after reset starts from pointer 0.
        busy_len = 3;
        rbase    = ready_count[2];
        exp_push(8'h41, 4'b0100, 4'b0100);
        req_push(2, 8'h41, 1'b1);
        wait_done(100);
        check("ready_pulses", 32'(ready_count[2] - rbase), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
